// File: rtl/vgaconsole_term_ctrl_if.sv
// Byte-stream input, vblank and text-buffer port bundle for the VGA console
// terminal controller. The controller side uses the master modport; the host
// / buffer side uses the slave modport.
interface vgaconsole_term_ctrl_if #(
    parameter int unsigned ADDR_W = 5
);
    logic              in_valid;
    logic [6:0]        in_data;
    logic              in_ready;
    logic              vblank;
    logic              buf_we;
    logic [ADDR_W-1:0] buf_waddr;
    logic [6:0]        buf_wdata;
    logic [ADDR_W-1:0] buf_raddr;
    logic [6:0]        buf_rdata;
    logic [1:0]        cursor_row;
    logic [3:0]        cursor_col;
    logic              busy;

    modport master (
        input  in_valid, in_data, vblank, buf_rdata,
        output in_ready, buf_we, buf_waddr, buf_wdata, buf_raddr,
               cursor_row, cursor_col, busy
    );

    modport slave (
        output in_valid, in_data, vblank, buf_rdata,
        input  in_ready, buf_we, buf_waddr, buf_wdata, buf_raddr,
               cursor_row, cursor_col, busy
    );
endinterface

// File: rtl/vgaconsole_term_ctrl.sv
// Terminal controller for the VGA console text buffer. Accepts a character
// stream, tracks the cursor, writes printable characters and backspace
// blanks, and performs vblank-gated scroll and full-screen clear sequences.
module vgaconsole_term_ctrl #(
    parameter int unsigned NUM_ROWS = 3,
    parameter int unsigned NUM_COLS = 10,
    parameter int unsigned ADDR_W   = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    vgaconsole_term_ctrl_if.master bus
);
    localparam int unsigned       CELLS     = NUM_ROWS * NUM_COLS;
    localparam logic [ADDR_W-1:0] COPY_LAST = ADDR_W'((NUM_ROWS - 1) * NUM_COLS - 1);
    localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(CELLS - 1);
    localparam logic [1:0]        ROW_LAST  = 2'(NUM_ROWS - 1);
    localparam logic [3:0]        COL_LAST  = 4'(NUM_COLS - 1);

    localparam logic [6:0] CH_SPACE = 7'h20;
    localparam logic [6:0] CH_TILDE = 7'h7E;
    localparam logic [6:0] CH_BS    = 7'h08;
    localparam logic [6:0] CH_LF    = 7'h0A;
    localparam logic [6:0] CH_FF    = 7'h0C;
    localparam logic [6:0] CH_CR    = 7'h0D;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_VB,
        SCROLL,
        CLEAR_ROW,
        CLEAR_ALL
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              op_clear_all_q, op_clear_all_d;
    logic [1:0]        row_q, row_d;
    logic [3:0]        col_q, col_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [6:0]        wdata_q, wdata_d;

    logic              accept;
    logic              newline;
    logic [ADDR_W-1:0] cur_addr;

    assign accept   = bus.in_valid && (state_q == IDLE);
    assign cur_addr = ADDR_W'(32'(row_q) * NUM_COLS + 32'(col_q));

    // Output mapping: handshake and busy from state, buffer port from registers
    assign bus.in_ready   = (state_q == IDLE);
    assign bus.busy       = (state_q != IDLE);
    assign bus.buf_we     = we_q;
    assign bus.buf_waddr  = waddr_q;
    assign bus.buf_wdata  = wdata_q;
    assign bus.cursor_row = row_q;
    assign bus.cursor_col = col_q;
    assign bus.buf_raddr  = (state_q == SCROLL) ? ADDR_W'(32'(idx_q) + NUM_COLS) : '0;

    // State, cursor, counter and registered write-port update
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            idx_q          <= '0;
            op_clear_all_q <= 1'b0;
            row_q          <= '0;
            col_q          <= '0;
            we_q           <= 1'b0;
            waddr_q        <= '0;
            wdata_q        <= '0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            op_clear_all_q <= op_clear_all_d;
            row_q          <= row_d;
            col_q          <= col_d;
            we_q           <= we_d;
            waddr_q        <= waddr_d;
            wdata_q        <= wdata_d;
        end
    end

    // Byte decoding, scroll/clear sequencing and next write selection
    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        op_clear_all_d = op_clear_all_q;
        row_d          = row_q;
        col_d          = col_q;
        we_d           = 1'b0;
        waddr_d        = waddr_q;
        wdata_d        = wdata_q;
        newline        = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (bus.in_data >= CH_SPACE && bus.in_data <= CH_TILDE) begin
                        we_d    = 1'b1;
                        waddr_d = cur_addr;
                        wdata_d = bus.in_data;
                        if (col_q < COL_LAST) begin
                            col_d = col_q + 4'd1;
                        end else begin
                            newline = 1'b1;
                        end
                    end else begin
                        case (bus.in_data)
                            CH_LF: newline = 1'b1;
                            CH_CR: col_d = '0;
                            CH_BS: begin
                                if (col_q != '0) begin
                                    col_d   = col_q - 4'd1;
                                    we_d    = 1'b1;
                                    waddr_d = cur_addr - ADDR_W'(1);
                                    wdata_d = CH_SPACE;
                                end
                            end
                            CH_FF: begin
                                state_d        = WAIT_VB;
                                op_clear_all_d = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                // Shared by wrap and LF: the cursor stays on the last row while
                // the scroll is pending, and is re-homed when it completes.
                if (newline) begin
                    col_d = '0;
                    if (row_q < ROW_LAST) begin
                        row_d = row_q + 2'd1;
                    end else begin
                        state_d        = WAIT_VB;
                        op_clear_all_d = 1'b0;
                    end
                end
            end

            WAIT_VB: begin
                if (bus.vblank) begin
                    idx_d   = '0;
                    state_d = op_clear_all_q ? CLEAR_ALL : SCROLL;
                end
            end

            // Reads run one row ahead of the write address, so each copy
            // reads a cell that has not been overwritten yet.
            SCROLL: begin
                we_d    = 1'b1;
                waddr_d = idx_q;
                wdata_d = bus.buf_rdata;
                idx_d   = idx_q + ADDR_W'(1);
                if (idx_q == COPY_LAST) begin
                    state_d = CLEAR_ROW;
                end
            end

            // idx continues from the end of the copy into the last row
            CLEAR_ROW: begin
                we_d    = 1'b1;
                waddr_d = idx_q;
                wdata_d = CH_SPACE;
                if (idx_q == LAST_CELL) begin
                    state_d = IDLE;
                    idx_d   = '0;
                    row_d   = ROW_LAST;
                    col_d   = '0;
                end else begin
                    idx_d = idx_q + ADDR_W'(1);
                end
            end

            CLEAR_ALL: begin
                we_d    = 1'b1;
                waddr_d = idx_q;
                wdata_d = CH_SPACE;
                if (idx_q == LAST_CELL) begin
                    state_d = IDLE;
                    idx_d   = '0;
                    row_d   = '0;
                    col_d   = '0;
                end else begin
                    idx_d = idx_q + ADDR_W'(1);
                end
            end

            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_vgaconsole_term_ctrl.sv
// Self-checking bench for vgaconsole_term_ctrl: directed checks of write
// timing, scroll, clear, backspace and mid-scroll reset, then a randomized
// byte stream compared against a screen/cursor reference model.
module tb_vgaconsole_term_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;

    vgaconsole_term_ctrl_if #(.ADDR_W(5)) ifc ();

    vgaconsole_term_ctrl #(
        .NUM_ROWS(3),
        .NUM_COLS(10),
        .ADDR_W  (5)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(ifc)
    );

    always #5 clk = ~clk;

    // Text buffer memory behind the write/read ports
    logic [6:0] mem [30];
    bit         mem_ready = 1'b0;
    int unsigned cyc = 0;

    typedef struct {
        int unsigned cyc;
        logic [4:0]  addr;
        logic [6:0]  data;
    } wr_t;
    wr_t wlog[$];

    assign ifc.buf_rdata = (ifc.buf_raddr < 5'd30) ? mem[ifc.buf_raddr] : 7'h00;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!mem_ready) begin
            for (int i = 0; i < 30; i++) mem[i] <= 7'h20;
            mem_ready <= 1'b1;
        end else if (ifc.buf_we) begin
            if (ifc.buf_waddr < 5'd30) mem[ifc.buf_waddr] <= ifc.buf_wdata;
            wlog.push_back('{cyc, ifc.buf_waddr, ifc.buf_wdata});
        end
    end

    // Reference model: screen contents and cursor after each accepted byte
    logic [6:0] m_scr [30];
    logic [6:0] old   [30];
    int m_row = 0;
    int m_col = 0;

    function automatic void m_newline();
        m_col = 0;
        if (m_row < 2) begin
            m_row++;
        end else begin
            for (int i = 0; i < 20; i++) m_scr[i] = m_scr[i + 10];
            for (int i = 20; i < 30; i++) m_scr[i] = 7'h20;
        end
    endfunction

    function automatic void m_byte(input logic [6:0] c);
        if (c >= 7'h20 && c <= 7'h7E) begin
            m_scr[m_row * 10 + m_col] = c;
            if (m_col < 9) m_col++;
            else m_newline();
        end else if (c == 7'h0A) begin
            m_newline();
        end else if (c == 7'h0D) begin
            m_col = 0;
        end else if (c == 7'h08) begin
            if (m_col > 0) begin
                m_col--;
                m_scr[m_row * 10 + m_col] = 7'h20;
            end
        end else if (c == 7'h0C) begin
            for (int i = 0; i < 30; i++) m_scr[i] = 7'h20;
            m_row = 0;
            m_col = 0;
        end
    endfunction

    function automatic logic [255:0] pack_mem();
        logic [255:0] v = '0;
        for (int i = 0; i < 30; i++) v[i*7 +: 7] = mem[i];
        return v;
    endfunction

    function automatic logic [255:0] pack_model();
        logic [255:0] v = '0;
        for (int i = 0; i < 30; i++) v[i*7 +: 7] = m_scr[i];
        return v;
    endfunction

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_cursor(input string tag);
        check({tag, "_row"}, 256'(ifc.cursor_row), 256'(m_row));
        check({tag, "_col"}, 256'(ifc.cursor_col), 256'(m_col));
    endtask

    // Entered and left at a negedge; the accepted byte's write is visible on return
    task automatic send(input logic [6:0] c, input bit rand_vb);
        int unsigned n = 0;
        ifc.in_valid = 1'b1;
        ifc.in_data  = c;
        while (!ifc.in_ready && n < 200) begin
            if (rand_vb) ifc.vblank = ($urandom_range(0, 3) == 0);
            @(negedge clk);
            n++;
        end
        check("accept_wait", 256'(ifc.in_ready), 256'(1));
        @(posedge clk);
        m_byte(c);
        @(negedge clk);
        ifc.in_valid = 1'b0;
    endtask

    task automatic wait_idle(input bit rand_vb);
        int unsigned n = 0;
        while (ifc.busy && n < 200) begin
            if (rand_vb) ifc.vblank = ($urandom_range(0, 3) == 0);
            @(negedge clk);
            n++;
        end
        check("idle_wait", 256'(ifc.busy), 256'(0));
        @(negedge clk);
    endtask

    // Checks n consecutive logged writes starting at base: address base_addr+i
    task automatic check_run(input string tag, input int base, input int n,
                             input int base_addr, input bit copy);
        check({tag, "_count"}, 256'(wlog.size() - base), 256'(n));
        if (wlog.size() - base == n) begin
            for (int i = 0; i < n; i++) begin
                logic [6:0] exp_d;
                exp_d = (copy && i < 20) ? old[i + 10] : 7'h20;
                check({tag, "_addr"}, 256'(wlog[base + i].addr), 256'(base_addr + i));
                check({tag, "_data"}, 256'(wlog[base + i].data), 256'(exp_d));
                check({tag, "_cyc"}, 256'(wlog[base + i].cyc - wlog[base].cyc), 256'(i));
            end
        end
    endtask

    initial begin
        int base;
        int nb;
        logic [6:0] c;
        int r;

        for (int i = 0; i < 30; i++) m_scr[i] = 7'h20;
        ifc.in_valid = 1'b0;
        ifc.in_data  = 7'h00;
        ifc.vblank   = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst_ready", 256'(ifc.in_ready), 256'(1));
        check("rst_busy", 256'(ifc.busy), 256'(0));
        check("rst_we", 256'(ifc.buf_we), 256'(0));
        check("rst_waddr", 256'(ifc.buf_waddr), 256'(0));
        check("rst_wdata", 256'(ifc.buf_wdata), 256'(0));
        check("rst_raddr", 256'(ifc.buf_raddr), 256'(0));
        check_cursor("rst");

        // "HI" back to back
        ifc.in_valid = 1'b1;
        ifc.in_data  = 7'h48;
        @(posedge clk);
        m_byte(7'h48);
        @(negedge clk);
        check("hi0_we", 256'(ifc.buf_we), 256'(1));
        check("hi0_addr", 256'(ifc.buf_waddr), 256'(0));
        check("hi0_data", 256'(ifc.buf_wdata), 256'(7'h48));
        check_cursor("hi0");
        ifc.in_data = 7'h49;
        @(posedge clk);
        m_byte(7'h49);
        @(negedge clk);
        ifc.in_valid = 1'b0;
        check("hi1_we", 256'(ifc.buf_we), 256'(1));
        check("hi1_addr", 256'(ifc.buf_waddr), 256'(1));
        check("hi1_data", 256'(ifc.buf_wdata), 256'(7'h49));
        check("hi1_col", 256'(ifc.cursor_col), 256'(2));
        check("hi1_row", 256'(ifc.cursor_row), 256'(0));
        @(negedge clk);
        check("hi_we_off", 256'(ifc.buf_we), 256'(0));
        check("hi_busy", 256'(ifc.busy), 256'(0));

        // Form feed with vblank already high
        ifc.vblank = 1'b1;
        base = wlog.size();
        send(7'h0C, 1'b0);
        nb = 0;
        while (!ifc.in_ready && nb < 100) begin
            @(negedge clk);
            nb++;
        end
        check("ff_busy_cycles", 256'(nb), 256'(31));
        @(negedge clk);
        ifc.vblank = 1'b0;
        check_run("ff", base, 30, 0, 1'b0);
        check_cursor("ff");
        check("ff_screen", pack_mem(), pack_model());

        // Ten 'A' from home, one per cycle
        base = wlog.size();
        ifc.in_valid = 1'b1;
        ifc.in_data  = 7'h41;
        repeat (10) begin
            @(posedge clk);
            m_byte(7'h41);
        end
        @(negedge clk);
        ifc.in_valid = 1'b0;
        @(negedge clk);
        check("a10_count", 256'(wlog.size() - base), 256'(10));
        if (wlog.size() - base == 10) begin
            for (int i = 0; i < 10; i++) begin
                check("a10_addr", 256'(wlog[base + i].addr), 256'(i));
                check("a10_cyc", 256'(wlog[base + i].cyc - wlog[base].cyc), 256'(i));
            end
        end
        check("a10_row", 256'(ifc.cursor_row), 256'(1));
        check("a10_col", 256'(ifc.cursor_col), 256'(0));
        check("a10_busy", 256'(ifc.busy), 256'(0));

        // Fill 'B' row, 9 'C', CR, then LF held off by vblank
        repeat (10) send(7'h42, 1'b0);
        repeat (9) send(7'h43, 1'b0);
        send(7'h0D, 1'b0);
        check("fill_row", 256'(ifc.cursor_row), 256'(2));
        check("fill_col", 256'(ifc.cursor_col), 256'(0));
        @(negedge clk);
        old = m_scr;
        base = wlog.size();
        send(7'h0A, 1'b0);
        repeat (20) @(negedge clk);
        check("lf_hold_busy", 256'(ifc.busy), 256'(1));
        check("lf_hold_ready", 256'(ifc.in_ready), 256'(0));
        check("lf_hold_writes", 256'(wlog.size() - base), 256'(0));
        ifc.vblank = 1'b1;
        nb = 0;
        while (!ifc.in_ready && nb < 100) begin
            @(negedge clk);
            nb++;
        end
        check("scroll_cycles", 256'(nb), 256'(31));
        @(negedge clk);
        ifc.vblank = 1'b0;
        check_run("scroll", base, 30, 0, 1'b1);
        check_cursor("scroll");
        check("scroll_screen", pack_mem(), pack_model());

        // Backspace at row 1 col 3, then at col 0
        ifc.vblank = 1'b1;
        send(7'h0C, 1'b0);
        wait_idle(1'b0);
        ifc.vblank = 1'b0;
        send(7'h0A, 1'b0);
        send(7'h61, 1'b0);
        send(7'h62, 1'b0);
        send(7'h63, 1'b0);
        send(7'h08, 1'b0);
        check("bs_we", 256'(ifc.buf_we), 256'(1));
        check("bs_addr", 256'(ifc.buf_waddr), 256'(12));
        check("bs_data", 256'(ifc.buf_wdata), 256'(7'h20));
        check_cursor("bs");
        send(7'h0D, 1'b0);
        @(negedge clk);
        base = wlog.size();
        send(7'h08, 1'b0);
        check("bs0_we", 256'(ifc.buf_we), 256'(0));
        @(negedge clk);
        check("bs0_writes", 256'(wlog.size() - base), 256'(0));
        check_cursor("bs0");

        // Reset in the middle of a scroll, at idx 7
        send(7'h0A, 1'b0);
        @(negedge clk);
        ifc.vblank = 1'b1;
        old = m_scr;
        base = wlog.size();
        send(7'h0A, 1'b0);
        repeat (8) @(negedge clk);
        check("mid_we_before", 256'(ifc.buf_we), 256'(1));
        #1 rst = 1'b1;
        #1;
        check("mid_we", 256'(ifc.buf_we), 256'(0));
        check("mid_row", 256'(ifc.cursor_row), 256'(0));
        check("mid_col", 256'(ifc.cursor_col), 256'(0));
        check("mid_ready", 256'(ifc.in_ready), 256'(1));
        check("mid_busy", 256'(ifc.busy), 256'(0));
        check("mid_writes", 256'(wlog.size() - base), 256'(6));
        m_scr = old;
        for (int i = 0; i < 6; i++) m_scr[i] = old[i + 10];
        m_row = 0;
        m_col = 0;
        @(negedge clk);
        rst = 1'b0;
        ifc.vblank = 1'b0;
        @(negedge clk);
        check("mid_screen", pack_mem(), pack_model());
        send(7'h5A, 1'b0);
        check("z_we", 256'(ifc.buf_we), 256'(1));
        check("z_addr", 256'(ifc.buf_waddr), 256'(0));
        check("z_data", 256'(ifc.buf_wdata), 256'(7'h5A));

        // Randomized byte stream against the model
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 99);
            if (r < 55)      c = 7'($urandom_range(32, 126));
            else if (r < 67) c = 7'h0A;
            else if (r < 72) c = 7'h0D;
            else if (r < 84) c = 7'h08;
            else if (r < 87) c = 7'h0C;
            else if (r < 97) c = 7'($urandom_range(0, 31));
            else             c = 7'h7F;
            ifc.vblank = ($urandom_range(0, 1) == 1);
            send(c, 1'b1);
            wait_idle(1'b1);
            check("rnd_raddr", 256'(ifc.buf_raddr), 256'(0));
            check_cursor("rnd");
            check("rnd_screen", pack_mem(), pack_model());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
